// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, parked in pending registers, and committed when the busy counter expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CntW      = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntMult = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] CntDiv  = CntW'(DIV_CYCLES);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } op_e;

    op_e opSel;

    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pendHi_q, pendHi_d;
    logic [31:0]     pendLo_q, pendLo_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] divisor;
    logic [31:0] quotS, remS;
    logic [31:0] quotU, remU;
    logic        divByZero;
    logic        divOverflow;

    assign opSel = op_e'(op);

    // Arithmetic datapath; a zero divisor is swapped for 1 so the divider never sees it.
    always_comb begin
        divByZero   = (B == 32'd0);
        divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        divisor     = divByZero ? 32'd1 : B;

        prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU = {32'd0, A} * {32'd0, B};

        quotS = $signed(A) / $signed(divisor);
        remS  = $signed(A) % $signed(divisor);
        if (divOverflow) begin
            quotS = 32'h8000_0000;
            remS  = 32'd0;
        end

        quotU = A / divisor;
        remU  = A % divisor;
    end

    // Next-state: issue only when idle; a divide by zero parks the current HI/LO so the commit is a no-op.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        pendHi_d = pendHi_q;
        pendLo_d = pendLo_q;
        cnt_d    = cnt_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
                hi_d = pendHi_q;
                lo_d = pendLo_q;
            end
        end else if (start) begin
            case (opSel)
                OpMult: begin
                    {pendHi_d, pendLo_d} = prodS;
                    cnt_d                = CntMult;
                end
                OpMultu: begin
                    {pendHi_d, pendLo_d} = prodU;
                    cnt_d                = CntMult;
                end
                OpDiv: begin
                    {pendHi_d, pendLo_d} = divByZero ? {hi_q, lo_q} : {remS, quotS};
                    cnt_d                = CntDiv;
                end
                OpDivu: begin
                    {pendHi_d, pendLo_d} = divByZero ? {hi_q, lo_q} : {remU, quotU};
                    cnt_d                = CntDiv;
                end
                OpMthi:  hi_d = A;
                OpMtlo:  lo_d = A;
                default: ;
            endcase
        end
    end

    // State registers; reset clears everything and aborts an in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pendHi_q <= 32'd0;
            pendLo_q <= 32'd0;
            cnt_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pendHi_q <= pendHi_d;
            pendLo_q <= pendLo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: timing, arithmetic corner cases, reset abort and back-to-back issue.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int compared;
    int mismatched;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one start pulse for a single cycle; called and returns on a falling edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Counts busy cycles (bounded) and how many of them showed HI/LO different from the held values.
    task automatic waitBusy(input logic [31:0] holdHi, input logic [31:0] holdLo,
                            output int cycles, output int holdErr);
        cycles  = 0;
        holdErr = 0;
        while (busy === 1'b1 && cycles < 40) begin
            if (HI !== holdHi || LO !== holdLo) holdErr++;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        #3;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        compared++;
        if (HI !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hi: got %h expected 00000000", HI);
        end
        compared++;
        if (LO !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_lo: got %h expected 00000000", LO);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult_timing;
        int n, he;
        applyStimulus(3'd5, 32'h0000_AAAA, 32'd0);
        applyStimulus(3'd6, 32'h0000_BBBB, 32'd0);
        applyStimulus(3'd1, 32'hFFFF_FFFD, 32'd5);
        waitBusy(32'h0000_AAAA, 32'h0000_BBBB, n, he);
        compared++;
        if (n !== 5) begin
            mismatched++;
            $display("[TB] FAIL mult_busy_cycles: got %0d expected 5", n);
        end
        compared++;
        if (he !== 0) begin
            mismatched++;
            $display("[TB] FAIL mult_hold_old: got %0d changed cycles expected 0", he);
        end
        compared++;
        if (HI !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("[TB] FAIL mult_hi: got %h expected ffffffff", HI);
        end
        compared++;
        if (LO !== 32'hFFFF_FFF1) begin
            mismatched++;
            $display("[TB] FAIL mult_lo: got %h expected fffffff1", LO);
        end
    endtask

    task automatic test_multu;
        int n, he;
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2);
        waitBusy(32'hFFFF_FFFF, 32'hFFFF_FFF1, n, he);
        compared++;
        if (HI !== 32'h0000_0001) begin
            mismatched++;
            $display("[TB] FAIL multu_hi: got %h expected 00000001", HI);
        end
        compared++;
        if (LO !== 32'hFFFF_FFFE) begin
            mismatched++;
            $display("[TB] FAIL multu_lo: got %h expected fffffffe", LO);
        end
    endtask

    task automatic test_div;
        int n, he;
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2);
        waitBusy(32'h0000_0001, 32'hFFFF_FFFE, n, he);
        compared++;
        if (n !== 10) begin
            mismatched++;
            $display("[TB] FAIL div_busy_cycles: got %0d expected 10", n);
        end
        compared++;
        if (LO !== 32'hFFFF_FFFD) begin
            mismatched++;
            $display("[TB] FAIL div_lo: got %h expected fffffffd", LO);
        end
        compared++;
        if (HI !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("[TB] FAIL div_hi: got %h expected ffffffff", HI);
        end
        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitBusy(32'hFFFF_FFFF, 32'hFFFF_FFFD, n, he);
        compared++;
        if (LO !== 32'h8000_0000) begin
            mismatched++;
            $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", LO);
        end
        compared++;
        if (HI !== 32'h0000_0000) begin
            mismatched++;
            $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", HI);
        end
    endtask

    task automatic test_divzero;
        int n;
        int he;
        applyStimulus(3'd5, 32'h0000_1234, 32'd0);
        compared++;
        if (HI !== 32'h0000_1234 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mthi: got HI=%h busy=%b expected 00001234/0", HI, busy);
        end
        applyStimulus(3'd6, 32'h0000_5678, 32'd0);
        compared++;
        if (LO !== 32'h0000_5678 || HI !== 32'h0000_1234 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mtlo: got HI=%h LO=%h busy=%b expected 00001234/00005678/0", HI, LO, busy);
        end
        applyStimulus(3'd4, 32'd7, 32'd0);
        n  = 0;
        he = 0;
        while (busy === 1'b1 && n < 40) begin
            if (HI !== 32'h0000_1234 || LO !== 32'h0000_5678) he++;
            start = (n == 3);
            op    = (n == 3) ? 3'd1 : 3'd0;
            A     = 32'd9;
            B     = 32'd9;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        op    = 3'd0;
        compared++;
        if (n !== 10) begin
            mismatched++;
            $display("[TB] FAIL divzero_busy_cycles: got %0d expected 10", n);
        end
        compared++;
        if (HI !== 32'h0000_1234 || LO !== 32'h0000_5678 || he !== 0) begin
            mismatched++;
            $display("[TB] FAIL divzero_unchanged: got HI=%h LO=%h changed=%0d expected 00001234/00005678/0", HI, LO, he);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || HI !== 32'h0000_1234 || LO !== 32'h0000_5678) begin
            mismatched++;
            $display("[TB] FAIL ignored_mult: got busy=%b HI=%h LO=%h expected 0/00001234/00005678", busy, HI, LO);
        end
    endtask

    task automatic test_reset_mid;
        applyStimulus(3'd3, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_async: got busy=%b HI=%h LO=%h expected 0/00000000/00000000", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_no_commit: got busy=%b HI=%h LO=%h expected 0/00000000/00000000", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int n, he;
        applyStimulus(3'd1, 32'd3, 32'd4);
        waitBusy(32'd0, 32'd0, n, he);
        compared++;
        if (n !== 5 || LO !== 32'd12 || HI !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got cycles=%0d HI=%h LO=%h expected 5/00000000/0000000c", n, HI, LO);
        end
        applyStimulus(3'd4, 32'd100, 32'd7);
        waitBusy(32'd0, 32'd12, n, he);
        compared++;
        if (n !== 10 || he !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy: got cycles=%0d changed=%0d expected 10/0", n, he);
        end
        compared++;
        if (LO !== 32'd14 || HI !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_result: got HI=%h LO=%h expected 00000002/0000000e", HI, LO);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_mult_timing();
        test_multu();
        test_div();
        test_divzero();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the Execute stage directly upstream of the Memory stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the Execute controller and holds the result for a fixed latency. It exposes `busy` so the hazard unit can stall, and drives HI/LO so that MFHI/MFLO results enter the EX/MEM register as the ALU output.

## Interface
- `MULT_CYCLES`, default 5: busy duration of a multiply.
- `DIV_CYCLES`, default 10: busy duration of a divide.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low. Clears all state immediately when 0.
- `start`  input  1  issue the operation on `op` in this cycle.
- `op`  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `A`  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `B`  input  32  rt operand (divisor / multiplier).
- `busy`  output  1  operation in flight.
- `HI`  output  32  architectural HI register.
- `LO`  output  32  architectural LO register.

## Operation
- State: `HI`, `LO`, pending result regs `pHI`/`pLO`, down-counter `cnt` (4 bits minimum; wide enough for max(MULT_CYCLES, DIV_CYCLES)).
- Idle (`cnt`==0): when `start`=1 and `op` is 1–4, the unit computes the result from `A`/`B` and latches it into `pHI`/`pLO`. It loads `cnt` with MULT_CYCLES or DIV_CYCLES.
- Busy (`cnt`!=0): `cnt` decrements each edge. On the edge where `cnt` goes 1→0, `pHI`/`pLO` are copied into `HI`/`LO`.
- `busy` = (`cnt`!=0), driven from the register, with no combinational path from `start`.
- MULT: signed 32×32 product, 64 bits. `HI`=[63:32], `LO`=[31:0].
- MULTU: the same as MULT, unsigned.
- DIV, signed:
  - `LO` = quotient, truncated toward zero.
  - `HI` = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `LO`=0x80000000, `HI`=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU with B==0):
  - The unit still goes busy for DIV_CYCLES.
  - `HI`/`LO` are left unchanged at completion.
- MTHI/MTLO when idle: `HI` or `LO` takes `A` at the edge. No busy period; the other register is unchanged.
- `start` while busy, for any op, is ignored. The hazard unit must stall any MD instruction and any MFHI/MFLO while `start`|`busy`.
- `op`=NONE or 7 with `start`=1: no effect.

## Timing
- Reset (`reset`=0, asynchronous): `HI`=0, `LO`=0, `pHI`=0, `pLO`=0, `cnt`=0, `busy`=0. Reset during a busy period aborts the operation and no result is committed.
- Reset release is sampled synchronously. The first operation may be accepted at the first rising edge with `reset`=1.
- Multiply timeline:
  - `start` high in cycle 0.
  - `busy`=1 in cycles 1..MULT_CYCLES.
  - New `HI`/`LO` visible in cycle MULT_CYCLES+1, where `busy`=0.
- Divide timeline: the same, with DIV_CYCLES.
- Back-to-back: a new `start` in the first cycle with `busy`=0 is accepted. The previous result is already visible in that cycle.
- MTHI/MTLO: visible in cycle 1; `busy` stays 0.
- Old `HI`/`LO` remain readable throughout the busy period.

## Test plan
- Multiply timing:
  - Stimulus: MULT, A=0xFFFFFFFD (−3), B=5.
  - Required: `busy` high for exactly 5 cycles; then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFF1.
  - During the busy period, `HI`/`LO` keep their prior values.
- Unsigned multiply:
  - Stimulus: MULTU, A=0xFFFFFFFF, B=2.
  - Required: `HI`=0x00000001, `LO`=0xFFFFFFFE.
- Signed divide:
  - DIV, A=0xFFFFFFF9 (−7), B=2: `busy` for 10 cycles; then `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
  - DIV, A=0x80000000, B=0xFFFFFFFF: `LO`=0x80000000, `HI`=0.
- Divide by zero and ignored start:
  - MTHI A=0x1234 then MTLO A=0x5678: each visible 1 cycle later with no busy.
  - DIVU 7/0: busy for 10 cycles; `HI`=0x1234, `LO`=0x5678 unchanged.
  - MULT issued during that busy period is ignored: no extra busy, no result.
- Reset mid-operation:
  - Stimulus: DIV started, `reset` pulled low in busy cycle 4.
  - Required: `busy`/`HI`/`LO` are 0 immediately, before the next clock edge.
  - Required: no commit after `reset` is released.
- Back-to-back:
  - Stimulus: MULT 3×4, then DIVU 100/7 issued in the first non-busy cycle.
  - Required: `LO`=12 is visible in that cycle.
  - Required: final result `LO`=14, `HI`=2.
